ex_wb_regfile: RTL and testbench
================================

Name: ex_wb_regfile

Overview:
- Receiving end of the execute-stage result interface (destination address, write-enable, result data).
- Captures each EX result into an EX/WB stage register, then commits it into a 32-entry integer register file on the next unstalled edge.
- Serves two combinational decode-stage read ports, with bypass from both the in-flight EX result and the pending WB entry.
- Keeps a retired-write counter for performance/debug visibility.

Parameters:
DATA_W, 32, register and result data width
ADDR_W, 5, register address width
REG_NUM, 32, number of architectural registers (2**ADDR_W)
CNT_W, 32, width of retired-write counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
stall  input  1  hold EX/WB stage register; suppress commit
flush  input  1  replace incoming EX result with a bubble
ex_wd_i  input  ADDR_W  EX destination register address
ex_wreg_i  input  1  EX result writes a register
ex_wdata_i  input  DATA_W  EX result data
re1_i  input  1  read port 1 enable
raddr1_i  input  ADDR_W  read port 1 address
rdata1_o  output  DATA_W  read port 1 data (combinational)
re2_i  input  1  read port 2 enable
raddr2_i  input  ADDR_W  read port 2 address
rdata2_o  output  DATA_W  read port 2 data (combinational)
wb_wd_o  output  ADDR_W  staged destination address
wb_wreg_o  output  1  staged write-enable
wb_wdata_o  output  DATA_W  staged data
retire_cnt_o  output  CNT_W  count of committed non-x0 writes

Behaviour:
- Reset (rst=1 at edge):
  - wb_wd_o=0, wb_wreg_o=0, wb_wdata_o=0, retire_cnt_o=0.
  - All REG_NUM registers cleared to 0.
  - Read outputs are 0 while rst=1.
  - Reset mid-operation discards the staged entry; it is never committed.
- Commit:
  - commit = !rst && !stall && wb_wreg_o.
  - On commit with wb_wd_o!=0: regs[wb_wd_o] <= wb_wdata_o and retire_cnt_o increments by 1.
  - The counter wraps modulo 2**CNT_W.
  - On commit with wb_wd_o==0: write discarded, counter unchanged.
- Stage register update (edge, rst=0), priority stall > flush > capture:
  - stall=1: hold all wb_* outputs. The held entry commits on the first edge with stall=0, exactly once.
  - flush=1 (stall=0): wb_wreg_o<=0, wb_wd_o<=0, wb_wdata_o<=0. The entry already staged at that edge still commits, because it is older than the flushed one.
  - otherwise: wb_* <= ex_*.
- Latency:
  - An EX result presented in cycle N appears on wb_* after edge N.
  - It is architecturally visible in regs after edge N+1, when unstalled.
- Read ports (identical, independent, purely combinational). First match wins:
  1. rst=1 -> 0.
  2. re=0 -> 0.
  3. addr=0 -> 0.
  4. ex_wreg_i=1 and addr==ex_wd_i -> ex_wdata_i (newest).
  5. wb_wreg_o=1 and addr==wb_wd_o -> wb_wdata_o.
  6. Otherwise -> regs[addr].
- Bypass detail:
  - EX bypass applies even when flush=1 in the same cycle; the decode/hazard logic is responsible for squashing.
  - Both ports may hit the same address and return the same value.
- x0 reads 0 in all cases, including when a pending EX or WB result targets x0.
- No combinational path from the read ports to any registered state.

Test Plan:
1. Reset then read: after rst, read x1..x31 with re=1 -> all 0; retire_cnt_o=0.
2. Back-to-back writes: EX x5=0x0000_1234 at cycle 1, then x5=0xDEAD_BEEF at cycle 2. Reading x5 during cycle 2 -> 0xDEAD_BEEF (EX bypass beats WB). After the final commit, x5=0xDEAD_BEEF; retire_cnt_o=2.
3. WB bypass: EX x7=0x55 at cycle 1, EX idle at cycle 2. Read x7 in cycle 2 -> 0x55 from wb_wdata_o; after the next edge, regs[7]=0x55.
4. Stall: stage holds x3=0xA5A5_A5A5; assert stall 3 cycles. wb_* unchanged, retire_cnt_o unchanged. Deassert stall -> single commit, retire_cnt_o +1, x3=0xA5A5_A5A5.
5. Flush plus x0: stage x4=0x11, EX x6=0x22 with flush=1 -> x4 commits, wb_wreg_o=0 next, x6 stays 0. EX x0=0xFFFF_FFFF -> read x0 is 0, counter unchanged.
6. Mid-operation reset: stage x9=0x99 and assert rst -> x9 reads 0, wb_wreg_o=0, retire_cnt_o=0. Also preload retire_cnt_o to its max value via repeated writes (CNT_W overridden to 4): 16 commits -> wraps to 0.

Source files
------------

// File: rtl/ex_wb_regfile.sv
// ex_wb_regfile
// Write-back end of the pipeline. EX results are latched into an EX/WB
// stage register and committed into a 32-entry integer register file on the
// next unstalled edge. Two combinational decode read ports see the newest
// value: the in-flight EX result first, then the staged WB entry, then the
// architectural file. x0 is hard-wired to zero. A retired-write counter
// counts committed writes to x1..x31.
module ex_wb_regfile #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int REG_NUM = 32,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] ex_wd_i,
  input  logic              ex_wreg_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [ADDR_W-1:0] wb_wd_o,
  output logic              wb_wreg_o,
  output logic [DATA_W-1:0] wb_wdata_o,
  output logic [CNT_W-1:0]  retire_cnt_o
);

  logic [DATA_W-1:0] regs [REG_NUM];

  // A staged entry commits only when the pipe advances; rst is folded in so
  // an entry caught by reset is dropped rather than written.
  logic commit;
  logic commit_wr;

  assign commit    = !rst && !stall && wb_wreg_o;
  assign commit_wr = commit && (wb_wd_o != '0);

  // EX/WB stage register: stall holds, flush inserts a bubble, else capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_wd_o    <= '0;
      wb_wreg_o  <= 1'b0;
      wb_wdata_o <= '0;
    end else if (stall) begin
      wb_wd_o    <= wb_wd_o;
      wb_wreg_o  <= wb_wreg_o;
      wb_wdata_o <= wb_wdata_o;
    end else if (flush) begin
      wb_wd_o    <= '0;
      wb_wreg_o  <= 1'b0;
      wb_wdata_o <= '0;
    end else begin
      wb_wd_o    <= ex_wd_i;
      wb_wreg_o  <= ex_wreg_i;
      wb_wdata_o <= ex_wdata_i;
    end
  end

  // Architectural register file; x0 is never written so it stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
    end else if (commit_wr) begin
      regs[wb_wd_o] <= wb_wdata_o;
    end
  end

  // Retired-write counter; wraps naturally at 2**CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_o <= '0;
    end else if (commit_wr) begin
      retire_cnt_o <= retire_cnt_o + CNT_W'(1);
    end
  end

  // Read-port priority: reset, disabled, x0, EX bypass, WB bypass, file.
  // EX bypass ignores flush on purpose; squashing is the hazard unit's job.
  function automatic logic [DATA_W-1:0] read_port(
    input logic              rst_v,
    input logic              re,
    input logic [ADDR_W-1:0] addr,
    input logic              ex_wreg,
    input logic [ADDR_W-1:0] ex_wd,
    input logic [DATA_W-1:0] ex_wdata,
    input logic              wb_wreg,
    input logic [ADDR_W-1:0] wb_wd,
    input logic [DATA_W-1:0] wb_wdata,
    input logic [DATA_W-1:0] reg_val
  );
    logic [DATA_W-1:0] val;
    val = '0;
    if (rst_v || !re || (addr == '0)) begin
      val = '0;
    end else if (ex_wreg && (addr == ex_wd)) begin
      val = ex_wdata;
    end else if (wb_wreg && (addr == wb_wd)) begin
      val = wb_wdata;
    end else begin
      val = reg_val;
    end
    return val;
  endfunction

  // Read port 1.
  always_comb begin
    rdata1_o = read_port(rst, re1_i, raddr1_i,
                         ex_wreg_i, ex_wd_i, ex_wdata_i,
                         wb_wreg_o, wb_wd_o, wb_wdata_o,
                         regs[raddr1_i]);
  end

  // Read port 2.
  always_comb begin
    rdata2_o = read_port(rst, re2_i, raddr2_i,
                         ex_wreg_i, ex_wd_i, ex_wdata_i,
                         wb_wreg_o, wb_wd_o, wb_wdata_o,
                         regs[raddr2_i]);
  end

endmodule

// File: tb/tb_ex_wb_regfile.sv
// Directed bench for ex_wb_regfile, built with a 4-bit retire counter so
// the wrap can be reached quickly.
module tb_ex_wb_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] ex_wd_i;
  logic              ex_wreg_i;
  logic [DATA_W-1:0] ex_wdata_i;
  logic              re1_i;
  logic [ADDR_W-1:0] raddr1_i;
  logic [DATA_W-1:0] rdata1_o;
  logic              re2_i;
  logic [ADDR_W-1:0] raddr2_i;
  logic [DATA_W-1:0] rdata2_o;
  logic [ADDR_W-1:0] wb_wd_o;
  logic              wb_wreg_o;
  logic [DATA_W-1:0] wb_wdata_o;
  logic [CNT_W-1:0]  retire_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  ex_wb_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .REG_NUM(32),
    .CNT_W  (CNT_W)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .ex_wd_i     (ex_wd_i),
    .ex_wreg_i   (ex_wreg_i),
    .ex_wdata_i  (ex_wdata_i),
    .re1_i       (re1_i),
    .raddr1_i    (raddr1_i),
    .rdata1_o    (rdata1_o),
    .re2_i       (re2_i),
    .raddr2_i    (raddr2_i),
    .rdata2_o    (rdata2_o),
    .wb_wd_o     (wb_wd_o),
    .wb_wreg_o   (wb_wreg_o),
    .wb_wdata_o  (wb_wdata_o),
    .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  a1;
    logic        re2;
    logic [4:0]  a2;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic        exp_wreg;
    logic [4:0]  exp_wd;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic s, input logic f, input logic [4:0] wd, input logic wr,
    input logic [31:0] wdat, input logic r1, input logic [4:0] a1,
    input logic r2, input logic [4:0] a2, input logic [31:0] e1,
    input logic [31:0] e2, input logic ew, input logic [4:0] ewd,
    input logic [31:0] ewdat, input logic [3:0] ec);
    vec_t v;
    v.stall = s;   v.flush = f;   v.wd = wd;   v.wreg = wr;  v.wdata = wdat;
    v.re1 = r1;    v.a1 = a1;     v.re2 = r2;  v.a2 = a2;
    v.exp_rd1 = e1; v.exp_rd2 = e2;
    v.exp_wreg = ew; v.exp_wd = ewd; v.exp_wdata = ewdat; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic f, input logic [4:0] wd,
                       input logic wr, input logic [31:0] wdat);
    stall = s; flush = f; ex_wd_i = wd; ex_wreg_i = wr; ex_wdata_i = wdat;
  endtask

  task automatic set_reads(input logic r1, input logic [4:0] a1,
                           input logic r2, input logic [4:0] a2);
    re1_i = r1; raddr1_i = a1; re2_i = r2; raddr2_i = a2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    set_reads(1'b1, 5'd5, 1'b1, 5'd9);
    tick();
    // Ports read zero under reset even with an EX hit present.
    drive(1'b0, 1'b0, 5'd5, 1'b1, 32'hCAFE_0001);
    #2;
    check("rst rd1", rdata1_o, 32'h0);
    check("rst rd2", rdata2_o, 32'h0);
    tick();
    check("rst wb_wreg", 32'(wb_wreg_o), 32'h0);
    check("rst wb_wd", 32'(wb_wd_o), 32'h0);
    check("rst wb_wdata", wb_wdata_o, 32'h0);
    check("rst cnt", 32'(retire_cnt_o), 32'h0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0);

    // All registers read zero after reset.
    for (int r = 1; r < 32; r++) begin
      set_reads(1'b1, 5'(r), 1'b1, 5'(32 - r));
      #1;
      check($sformatf("post-rst x%0d p1", r), rdata1_o, 32'h0);
      check($sformatf("post-rst x%0d p2", 32 - r), rdata2_o, 32'h0);
    end
    tick();

    // s f  wd wr wdata        re1 a1 re2 a2 | rd1          rd2          wreg wd  wdata        cnt
    vq.push_back(mk(0,0, 5,1,32'h0000_1234, 1, 5,1, 5, 32'h0000_1234,32'h0000_1234, 1, 5,32'h0000_1234, 0));
    vq.push_back(mk(0,0, 5,1,32'hDEAD_BEEF, 1, 5,1, 5, 32'hDEAD_BEEF,32'hDEAD_BEEF, 1, 5,32'hDEAD_BEEF, 1));
    vq.push_back(mk(0,0, 0,0,32'h0,         1, 5,0, 5, 32'hDEAD_BEEF,32'h0,         0, 0,32'h0,         2));
    vq.push_back(mk(0,0, 0,0,32'h0,         1, 5,1, 0, 32'hDEAD_BEEF,32'h0,         0, 0,32'h0,         2));
    vq.push_back(mk(0,0, 7,1,32'h55,        1, 7,1, 5, 32'h55,       32'hDEAD_BEEF, 1, 7,32'h55,        2));
    vq.push_back(mk(0,0, 0,0,32'h0,         1, 7,1, 7, 32'h55,       32'h55,        0, 0,32'h0,         3));
    vq.push_back(mk(0,0, 0,0,32'h0,         1, 7,1, 3, 32'h55,       32'h0,         0, 0,32'h0,         3));
    vq.push_back(mk(0,0, 3,1,32'hA5A5_A5A5, 1, 3,1, 3, 32'hA5A5_A5A5,32'hA5A5_A5A5, 1, 3,32'hA5A5_A5A5, 3));
    vq.push_back(mk(1,0, 8,1,32'h77,        1, 3,1, 8, 32'hA5A5_A5A5,32'h77,        1, 3,32'hA5A5_A5A5, 3));
    vq.push_back(mk(1,0, 0,0,32'h0,         1, 3,1, 8, 32'hA5A5_A5A5,32'h0,         1, 3,32'hA5A5_A5A5, 3));
    vq.push_back(mk(1,0, 0,0,32'h0,         1, 3,1, 8, 32'hA5A5_A5A5,32'h0,         1, 3,32'hA5A5_A5A5, 3));
    vq.push_back(mk(0,0, 0,0,32'h0,         1, 3,1, 8, 32'hA5A5_A5A5,32'h0,         0, 0,32'h0,         4));
    vq.push_back(mk(0,0, 0,0,32'h0,         1, 3,1, 8, 32'hA5A5_A5A5,32'h0,         0, 0,32'h0,         4));
    vq.push_back(mk(0,0, 4,1,32'h11,        1, 4,1, 6, 32'h11,       32'h0,         1, 4,32'h11,        4));
    vq.push_back(mk(0,1, 6,1,32'h22,        1, 6,1, 4, 32'h22,       32'h11,        0, 0,32'h0,         5));
    vq.push_back(mk(0,0, 0,0,32'h0,         1, 6,1, 4, 32'h0,        32'h11,        0, 0,32'h0,         5));
    vq.push_back(mk(0,0, 0,1,32'hFFFF_FFFF, 1, 0,1, 0, 32'h0,        32'h0,         1, 0,32'hFFFF_FFFF, 5));
    vq.push_back(mk(0,0, 0,0,32'h0,         1, 0,0, 0, 32'h0,        32'h0,         0, 0,32'h0,         5));
    vq.push_back(mk(0,0,10,1,32'hAB,        1,10,1,11, 32'hAB,       32'h0,         1,10,32'hAB,        5));
    vq.push_back(mk(1,1,11,1,32'hCD,        1,10,1,11, 32'hAB,       32'hCD,        1,10,32'hAB,        5));
    vq.push_back(mk(0,0, 0,0,32'h0,         1,10,1,11, 32'hAB,       32'h0,         0, 0,32'h0,         6));
    vq.push_back(mk(0,0, 0,0,32'h0,         1,10,1,11, 32'hAB,       32'h0,         0, 0,32'h0,         6));

    foreach (vq[i]) begin
      drive(vq[i].stall, vq[i].flush, vq[i].wd, vq[i].wreg, vq[i].wdata);
      set_reads(vq[i].re1, vq[i].a1, vq[i].re2, vq[i].a2);
      #2;
      check($sformatf("v%0d rd1", i), rdata1_o, vq[i].exp_rd1);
      check($sformatf("v%0d rd2", i), rdata2_o, vq[i].exp_rd2);
      tick();
      check($sformatf("v%0d wb_wreg", i), 32'(wb_wreg_o), 32'(vq[i].exp_wreg));
      check($sformatf("v%0d wb_wd", i), 32'(wb_wd_o), 32'(vq[i].exp_wd));
      check($sformatf("v%0d wb_wdata", i), wb_wdata_o, vq[i].exp_wdata);
      check($sformatf("v%0d cnt", i), 32'(retire_cnt_o), 32'(vq[i].exp_cnt));
    end

    // Mid-operation reset drops the staged x9 write.
    drive(1'b0, 1'b0, 5'd9, 1'b1, 32'h99);
    set_reads(1'b1, 5'd9, 1'b1, 5'd5);
    tick();
    check("midrst staged wd", 32'(wb_wd_o), 32'd9);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    rst = 1'b1;
    #2;
    check("midrst rd1 under rst", rdata1_o, 32'h0);
    check("midrst rd2 under rst", rdata2_o, 32'h0);
    tick();
    rst = 1'b0;
    #2;
    check("midrst wb_wreg", 32'(wb_wreg_o), 32'h0);
    check("midrst cnt", 32'(retire_cnt_o), 32'h0);
    check("midrst x9", rdata1_o, 32'h0);
    check("midrst x5 cleared", rdata2_o, 32'h0);
    tick();
    check("midrst x9 after edge", rdata1_o, 32'h0);
    check("midrst cnt after edge", 32'(retire_cnt_o), 32'h0);

    // Sixteen commits wrap the 4-bit counter back to zero.
    set_reads(1'b1, 5'd16, 1'b1, 5'd1);
    for (int k = 1; k <= 16; k++) begin
      drive(1'b0, 1'b0, 5'(k), 1'b1, 32'h100 + 32'(k));
      tick();
    end
    check("wrap cnt after 15", 32'(retire_cnt_o), 32'd15);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    tick();
    check("wrap cnt after 16", 32'(retire_cnt_o), 32'd0);
    check("wrap x16", rdata1_o, 32'h110);
    check("wrap x1", rdata2_o, 32'h101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
